// File: rtl/fsm_trace_logger_pkg.sv
// Shared widths, state codes and record layout for the FSM transition trace logger.
package fsm_trace_pkg;

    localparam int STATE_W = 3;
    localparam int DWELL_W = 8;
    localparam int REC_W   = 2 * STATE_W + DWELL_W;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_ONE   = 3'd1;
    localparam logic [STATE_W-1:0] S_TWO   = 3'd2;
    localparam logic [STATE_W-1:0] S_THREE = 3'd3;
    localparam logic [STATE_W-1:0] S_LOCK  = 3'd4;

    // Record layout, MSB first: {from, to, dwell}
    localparam int DWELL_LSB = 0;
    localparam int TO_LSB    = DWELL_W;
    localparam int FROM_LSB  = DWELL_W + STATE_W;

    function automatic logic [REC_W-1:0] pack_record(
        input logic [STATE_W-1:0] from_code,
        input logic [STATE_W-1:0] to_code,
        input logic [DWELL_W-1:0] dwell
    );
        return {from_code, to_code, dwell};
    endfunction

endpackage

// File: rtl/fsm_trace_logger_if.sv
// Read-side bus of the trace FIFO: the host pops records and watches occupancy.
interface fsm_trace_logger_if #(
    parameter int REC_W = fsm_trace_pkg::REC_W,
    parameter int CNT_W = 4
);

    logic             rd_en;
    logic [REC_W-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;

    modport master (output rd_en, input rd_data, empty, full, count);
    modport slave  (input rd_en, output rd_data, empty, full, count);

endinterface

// File: rtl/fsm_trace_logger_fifo.sv
// First-word-fall-through register FIFO; a push that cannot fit is dropped and flagged.
module trace_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A pop frees the slot in the same edge, so a full FIFO can still accept a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fsm_trace_logger.sv
// Watches the upstream FSM state code, logs every transition with its dwell time,
// and keeps lock / illegal-code / overflow status for the host.
module fsm_trace_logger
    import fsm_trace_pkg::*;
#(
    parameter int                 DEPTH     = 8,
    parameter logic [STATE_W-1:0] LOCK_CODE = S_LOCK,
    parameter logic [STATE_W-1:0] MAX_CODE  = S_LOCK
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [STATE_W-1:0]  state_in,
    input  logic                stat_clr,
    fsm_trace_logger_if.slave   rd,
    output logic                overflow,
    output logic                locked,
    output logic                lock_seen,
    output logic                illegal
);

    logic [STATE_W-1:0] prev_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               change;
    logic               is_lock;
    logic               is_illegal;
    logic               drop;
    logic [REC_W-1:0]   record;

    assign change     = (state_in != prev_q);
    assign is_lock    = (state_in == LOCK_CODE);
    assign is_illegal = (state_in > MAX_CODE);
    assign record     = pack_record(prev_q, state_in, dwell_q);

    // prev_q resets to the upstream reset code, so the first real transition is logged.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            prev_q  <= S_IDLE;
            dwell_q <= '0;
        end else if (change) begin
            prev_q  <= state_in;
            dwell_q <= DWELL_W'(1);
        end else if (dwell_q != '1) begin
            dwell_q <= dwell_q + 1'b1;
        end
    end

    // A flag raised in the same cycle as stat_clr must survive the clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            overflow  <= 1'b0;
            locked    <= 1'b0;
            lock_seen <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            locked    <= is_lock;
            overflow  <= drop       || (overflow  && !stat_clr);
            lock_seen <= is_lock    || (lock_seen && !stat_clr);
            illegal   <= is_illegal || (illegal   && !stat_clr);
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr_n     (clr_n),
        .push      (change),
        .push_data (record),
        .pop       (rd.rd_en),
        .pop_data  (rd.rd_data),
        .empty     (rd.empty),
        .full      (rd.full),
        .count     (rd.count),
        .drop      (drop)
    );

endmodule

// File: tb/tb_fsm_trace_logger.sv
// Scoreboard bench for fsm_trace_logger: directed scenarios plus random code streams.
module tb_fsm_trace_logger;
    import fsm_trace_pkg::*;

    localparam int DEPTH     = 8;
    localparam int CNT_W     = 4;
    localparam int DWELL_MAX = 255;

    logic               clk = 1'b0;
    logic               clr_n;
    logic [STATE_W-1:0] state_in;
    logic               stat_clr;
    logic               overflow;
    logic               locked;
    logic               lock_seen;
    logic               illegal;

    fsm_trace_logger_if #(.REC_W(REC_W), .CNT_W(CNT_W)) tr ();

    fsm_trace_logger #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .state_in  (state_in),
        .stat_clr  (stat_clr),
        .rd        (tr.slave),
        .overflow  (overflow),
        .locked    (locked),
        .lock_seen (lock_seen),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected FIFO contents, occupancy, current run and flags.
    logic [REC_W-1:0] exp_q[$];
    int occ;
    int last_code;
    int run_len;
    bit m_overflow;
    bit m_locked;
    bit m_lock_seen;
    bit m_illegal;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input int f, input int t, input int d);
        logic [REC_W-1:0] r;
        r = {3'(f), 3'(t), 8'(d)};
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        occ         = 0;
        last_code   = 0;
        run_len     = 0;
        m_overflow  = 0;
        m_locked    = 0;
        m_lock_seen = 0;
        m_illegal   = 0;
    endtask

    // Drive one cycle of inputs, then advance the model by the rules of that edge.
    task automatic applyStimulus(input int code, input bit rd, input bit clr);
        bit dropped;
        state_in = 3'(code);
        tr.rd_en = rd;
        stat_clr = clr;
        @(posedge clk);
        dropped = 0;
        if (rd && occ > 0) occ--;
        if (code != last_code) begin
            if (occ < DEPTH) begin
                exp_q.push_back(mk_rec(last_code, code, run_len));
                occ++;
            end else begin
                dropped = 1;
            end
            last_code = code;
            run_len   = 1;
        end else if (run_len < DWELL_MAX) begin
            run_len++;
        end
        m_locked    = (code == 4);
        m_overflow  = dropped     || (m_overflow  && !clr);
        m_lock_seen = (code == 4) || (m_lock_seen && !clr);
        m_illegal   = (code > 4)  || (m_illegal   && !clr);
        #1;
    endtask

    task automatic doReset();
        clr_n    = 1'b0;
        tr.rd_en = 1'b0;
        stat_clr = 1'b0;
        state_in = '0;
        #2;
        checkOutput("rst_empty", tr.empty, 1);
        checkOutput("rst_full", tr.full, 0);
        checkOutput("rst_count", tr.count, 0);
        checkOutput("rst_rd_data", tr.rd_data, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_lock_seen", lock_seen, 0);
        checkOutput("rst_illegal", illegal, 0);
        model_reset();
        #10;
        clr_n = 1'b1;
    endtask

    task automatic drain(input int code);
        int n;
        n = 0;
        while (occ > 0 && n < 64) begin
            applyStimulus(code, 1, 0);
            n++;
        end
        checks++;
        if (occ > 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0", occ);
        end
    endtask

    // Monitor: compare status every cycle and each popped head against the scoreboard.
    always @(negedge clk) begin
        if (clr_n) begin
            checkOutput("empty", tr.empty, occ == 0);
            checkOutput("full", tr.full, occ == DEPTH);
            checkOutput("count", tr.count, occ);
            checkOutput("overflow", overflow, m_overflow);
            checkOutput("locked", locked, m_locked);
            checkOutput("lock_seen", lock_seen, m_lock_seen);
            checkOutput("illegal", illegal, m_illegal);
            if (tr.empty) checkOutput("rd_data_when_empty", tr.rd_data, 0);
            if (tr.rd_en && !tr.empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_record actual=%0h required=none", tr.rd_data);
                end else begin
                    checkOutput("record", tr.rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int seq[12] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 4};
        int code;
        clr_n    = 1'b0;
        tr.rd_en = 1'b0;
        stat_clr = 1'b0;
        state_in = '0;
        #3;

        $display("[TB] dwell before first change");
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("t1_empty", tr.empty, 0);
        checkOutput("t1_count", tr.count, 1);
        checkOutput("t1_head", tr.rd_data, mk_rec(0, 1, 5));
        drain(1);

        $display("[TB] climb to lock");
        doReset();
        foreach (seq[i]) applyStimulus(seq[i], 0, 0);
        checkOutput("t2_head", tr.rd_data, mk_rec(0, 1, 1));
        checkOutput("t2_locked", locked, 1);
        for (int i = 0; i < 3; i++) applyStimulus(4, 0, 0);
        drain(4);
        checkOutput("t2_lock_seen", lock_seen, 1);

        $display("[TB] overflow on full");
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus((i % 2) + 1, 0, 0);
        checkOutput("t3_overflow", overflow, 1);
        checkOutput("t3_count", tr.count, 8);
        checkOutput("t3_head", tr.rd_data, mk_rec(0, 1, 0));
        drain(1);

        $display("[TB] full with concurrent reads");
        applyStimulus(1, 0, 1);
        checkOutput("t4_overflow_cleared", overflow, 0);
        for (int i = 0; i < 8; i++) applyStimulus((i % 2) ? 1 : 2, 0, 0);
        checkOutput("t4_full", tr.full, 1);
        for (int i = 0; i < 12; i++) applyStimulus((i % 2) ? 1 : 2, 1, 0);
        checkOutput("t4_count", tr.count, 8);
        checkOutput("t4_overflow", overflow, 0);
        drain(2);

        $display("[TB] illegal code with dwell saturation");
        doReset();
        for (int i = 0; i < 300; i++) applyStimulus(7, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("t5_illegal", illegal, 1);
        applyStimulus(0, 1, 0);
        checkOutput("t5_saturated", tr.rd_data, mk_rec(7, 0, 255));
        applyStimulus(0, 0, 1);
        checkOutput("t5_illegal_cleared", illegal, 0);
        drain(0);

        $display("[TB] reset mid-trace");
        doReset();
        applyStimulus(1, 0, 0);
        applyStimulus(2, 0, 0);
        applyStimulus(4, 0, 0);
        checkOutput("t6_count_before", tr.count, 3);
        doReset();

        $display("[TB] random stream");
        code = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 35) code = $urandom_range(7);
            applyStimulus(code, $urandom_range(99) < 40, $urandom_range(99) < 5);
        end
        drain(code);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_trace_logger.md
Name: fsm_trace_logger

Overview:
Downstream observer of the 3-bit state-code stream produced by the pattern FSM (codes 0..4, code 4 = absorbing lock). It samples the state code every cycle and detects changes. On each change it pushes a record {from, to, dwell} into a small first-word-fall-through (FWFT) FIFO that a host or bench drains. It also flags lock and illegal codes, giving the team a cycle-accurate transition trace without probing FSM internals.

Parameters:
STATE_W, 3, width of the state code
DWELL_W, 8, width of the dwell counter; saturates at 2^DWELL_W-1
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
LOCK_CODE, 4, state code treated as lock
MAX_CODE, 4, highest legal state code

Ports:
clk  in  1  system clock; all state updates on the rising edge
clr_n  in  1  asynchronous active-low reset
state_in  in  STATE_W  state code from the upstream FSM, sampled every cycle
rd_en  in  1  pop the head record; ignored when empty
stat_clr  in  1  synchronous clear of the sticky flags
rd_data  out  2*STATE_W+DWELL_W  head record, laid out as {from[13:11], to[10:8], dwell[7:0]} at the defaults
empty  out  1  FIFO holds no records
full  out  1  FIFO holds DEPTH records
count  out  log2(DEPTH)+1  number of records held
overflow  out  1  sticky: a record was dropped
locked  out  1  registered (state_in == LOCK_CODE)
lock_seen  out  1  sticky: LOCK_CODE has been observed
illegal  out  1  sticky: a code greater than MAX_CODE has been observed

Behaviour:
- Reset: clr_n low forces the following at once, independent of clk.
  - prev_q=0 (matches the upstream reset code) and dwell_q=0.
  - FIFO pointers=0, so empty=1, full=0, count=0.
  - overflow=0, locked=0, lock_seen=0, illegal=0.
  - rd_data=0.
- dwell_q is the number of consecutive samples equal to prev_q.
- Each cycle with no change (state_in == prev_q): dwell_q <= dwell_q+1, saturating at max.
- Each cycle with a change (state_in != prev_q):
  - build record {prev_q, state_in, dwell_q}; dwell_q may be 0 if the change occurs on the first sample after reset;
  - push the record;
  - prev_q <= state_in;
  - dwell_q <= 1.
- A record becomes visible on rd_data (empty falls) one cycle after the sampling edge.
- FIFO behaviour:
  - FWFT: rd_data always shows the head, and shows 0 when empty.
  - rd_en while not empty advances the head at the edge.
  - Push while not full writes the tail.
  - Push and pop together while full: both succeed, count is unchanged, no overflow.
  - Push and pop together while empty: the pop is ignored and the push succeeds.
  - Push while full with no pop: the record is dropped and overflow <= 1.
  - rd_en while empty: no effect and no flag.
  - Pointers carry log2(DEPTH)+1 bits: full is MSBs differing with the rest equal; empty is pointers equal; wrap-around is natural.
  - count = wr_ptr - rd_ptr.
- locked <= (state_in == LOCK_CODE) every cycle. It is not sticky, because an upstream clear leaves lock.
- Sticky flags:
  - lock_seen <= 1 on LOCK_CODE; illegal <= 1 when state_in > MAX_CODE.
  - Illegal codes are still recorded like any other code.
  - stat_clr clears all three sticky flags. A same-cycle set wins over stat_clr.
  - stat_clr does not touch the FIFO, prev_q or dwell_q.
- Reset mid-operation: all records are lost; the first post-reset change compares against prev_q=0.

Decomposition:
- Package fsm_trace_pkg holds:
  - STATE_W, DWELL_W and REC_W = 2*STATE_W+DWELL_W;
  - state code constants S_IDLE=0, S_ONE=1, S_TWO=2, S_THREE=3, S_LOCK=4;
  - the record field offsets.
- Sub-module trace_fifo (parameters WIDTH, DEPTH):
  - FWFT register-array FIFO with full, empty, count and a drop-on-full indication.
  - The top level holds the change detector, the dwell counter and the flags.

Test Plan:
- Reset, then state_in held at 0 for 5 cycles, then 1 -> one record {0,1,5}; empty falls the next cycle; count=1.
- Sequence 0,1,1,2,2,2,3,3,3,3,3,4, then 4 held; 4 drained -> records {0,1,1},{1,2,2},{2,3,3},{3,4,5}; locked=1 from the cycle after the first 4; lock_seen stays 1.
- Alternate 1/2 each cycle with no reads -> full after 8 records; 9th change sets overflow=1; drain yields the first 8 in order.
- Full FIFO with rd_en held high while changes continue -> count stays 8, overflow stays 0; records come out in order.
- Hold state_in=7 for 300 cycles, then 0 -> illegal=1; record {7,0,255} (saturation). Then stat_clr -> illegal=0.
- Assert clr_n low mid-trace with 3 records queued -> empty=1, count=0 and all flags 0 immediately, without a clock edge.
